// File: rtl/sc1_uart_loader.sv
// UART byte-stream frame decoder producing SoC write transactions.
// Optional checksum byte enabled by defining UART_LOADER_CHECKSUM_EN.
module sc1_uart_loader #(
  parameter int         ADDR_BYTES     = 4,
  parameter int         DATA_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] START_BYTE     = 8'haa,
  parameter logic [7:0] END_BYTE       = 8'h55
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_BYTES*8-1:0] wr_addr,
  output logic [DATA_BYTES*8-1:0] wr_data,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CSUM, S_END, S_OUT
  } state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_END, S_OUT
  } state_t;
`endif

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] tcnt;
  logic          in_frame;

  assign in_frame = (state != S_IDLE) && (state != S_OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      tcnt      <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == START_BYTE) begin
            state <= S_ADDR;
            busy  <= 1'b1;
            idx   <= '0;
            tcnt  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            wr_addr[8*idx +: 8] <= rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (idx == 3'(ADDR_BYTES-1)) begin
              idx   <= '0;
              state <= S_DATA;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            wr_data[8*idx +: 8] <= rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (idx == 3'(DATA_BYTES-1)) begin
              idx <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_END;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state <= S_END;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
        end
`endif
        S_END: begin
          if (rx_valid) begin
            if (rx_data == END_BYTE) begin
              state    <= S_OUT;
              wr_valid <= 1'b1;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
        end
        S_OUT: begin
          // Bytes arriving while a write is pending are dropped.
          if (rx_valid) frame_err <= 1'b1;
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
        end
      endcase

      if (in_frame) begin
        if (rx_valid) begin
          tcnt <= '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES-1)) begin
          tcnt      <= '0;
          state     <= S_IDLE;
          busy      <= 1'b0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (frame_err && err_count != 8'hff) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule
